// File: rtl/tf_mul_pipe.sv
// rtl/tf_mul_pipe.sv - 3-stage pipelined floating-point multiplier with valid/ready flow control
module tf_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 10,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_rnd_mode,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic         out_ovf,
  output logic         out_unf
);

  localparam int SW = MAN_W + 1;
  localparam int PW = 2 * SW;
  localparam int EW = EXP_W + 2;
  localparam logic [EW-1:0] BIAS  = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic [EW-1:0] E_SAT = EW'((1 << EXP_W) - 1);

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic [EXP_W-1:0] a_exp, b_exp;
  logic [SW-1:0]    a_sig, b_sig;
  assign a_exp = in_a[W-2 -: EXP_W];
  assign b_exp = in_b[W-2 -: EXP_W];
  assign a_sig = {1'b1, in_a[MAN_W-1:0]};
  assign b_sig = {1'b1, in_b[MAN_W-1:0]};

  logic          s1_valid, s1_zero, s1_sign, s1_rnd;
  logic [PW-1:0] s1_prod;
  logic [EW-1:0] s1_esum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_zero  <= 1'b0;
      s1_sign  <= 1'b0;
      s1_rnd   <= 1'b0;
      s1_prod  <= '0;
      s1_esum  <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_zero  <= (a_exp == '0) || (b_exp == '0);
      s1_sign  <= in_a[W-1] ^ in_b[W-1];
      s1_rnd   <= in_rnd_mode;
      s1_prod  <= PW'(a_sig) * PW'(b_sig);
      s1_esum  <= EW'(a_exp) + EW'(b_exp);
    end
  end

  // Normalise by one position at most, then round on guard/sticky.
  logic             norm, guard, sticky, inc, carry;
  logic [MAN_W-1:0] man_trunc, man_rnd;
  logic [EW-1:0]    e_next;

  always_comb begin
    norm      = s1_prod[PW-1];
    man_trunc = norm ? s1_prod[PW-2 -: MAN_W] : s1_prod[PW-3 -: MAN_W];
    guard     = norm ? s1_prod[PW-2-MAN_W] : s1_prod[PW-3-MAN_W];
    sticky    = norm ? (|s1_prod[PW-3-MAN_W:0]) : (|s1_prod[PW-4-MAN_W:0]);
    inc       = !s1_rnd && guard && (sticky || man_trunc[0]);
    {carry, man_rnd} = {1'b0, man_trunc} + SW'(inc);
    e_next    = s1_esum - BIAS + EW'(norm) + EW'(carry);
  end

  logic             s2_valid, s2_zero, s2_sign;
  logic [MAN_W-1:0] s2_man;
  logic [EW-1:0]    s2_e;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_zero  <= 1'b0;
      s2_sign  <= 1'b0;
      s2_man   <= '0;
      s2_e     <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_zero  <= s1_zero;
      s2_sign  <= s1_sign;
      s2_man   <= man_rnd;
      s2_e     <= e_next;
    end
  end

  // s2_e is two's complement; its MSB marks a negative biased exponent.
  logic e_neg;
  assign e_neg = s2_e[EW-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_ovf    <= 1'b0;
      out_unf    <= 1'b0;
    end else if (adv) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        if (s2_zero) begin
          out_result <= '0;
          out_ovf    <= 1'b0;
          out_unf    <= 1'b0;
        end else if (!e_neg && (s2_e >= E_SAT)) begin
          out_result <= {s2_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
          out_ovf    <= 1'b1;
          out_unf    <= 1'b0;
        end else if (e_neg || (s2_e == '0)) begin
          out_result <= '0;
          out_ovf    <= 1'b0;
          out_unf    <= 1'b1;
        end else begin
          out_result <= {s2_sign, s2_e[EXP_W-1:0], s2_man};
          out_ovf    <= 1'b0;
          out_unf    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_tf_mul_pipe.sv
// tb/tb_tf_mul_pipe.sv - randomized and directed self-checking bench for tf_mul_pipe
module tb_tf_mul_pipe;

  localparam int EXP_W = 8;
  localparam int MAN_W = 10;
  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int BIAS  = (1 << (EXP_W - 1)) - 1;

  logic         clk, rst_n;
  logic         in_valid, in_ready, in_rnd_mode;
  logic [W-1:0] in_a, in_b;
  logic         out_valid, out_ready, out_ovf, out_unf;
  logic [W-1:0] out_result;

  int n_vec, n_err;
  logic [W+1:0] expq[$];

  tf_mul_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_rnd_mode(in_rnd_mode),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_ovf(out_ovf), .out_unf(out_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact integer product, locate leading one, round the remainder arithmetically.
  function automatic logic [W+1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
    int ea, eb, k, sh, e;
    longint p, q, rem, half;
    logic sgn;
    logic [W-1:0] r;
    ea = int'(a[W-2:MAN_W]);
    eb = int'(b[W-2:MAN_W]);
    sgn = a[W-1] ^ b[W-1];
    if (ea == 0 || eb == 0) return '0;
    p = longint'((1 << MAN_W) + int'(a[MAN_W-1:0])) * longint'((1 << MAN_W) + int'(b[MAN_W-1:0]));
    k = 0;
    for (int i = 0; i < 40; i++) if (((p >> i) & 1) != 0) k = i;
    sh   = k - MAN_W;
    q    = p >> sh;
    rem  = p - (q << sh);
    half = longint'(1) << (sh - 1);
    if (!m && (rem > half || (rem == half && (q % 2) == 1))) q = q + 1;
    if (q == (longint'(1) << (MAN_W + 1))) begin
      q = q >> 1;
      k = k + 1;
    end
    e = ea + eb - BIAS + (k - 2 * MAN_W);
    if (e >= (1 << EXP_W) - 1) begin
      r = {sgn, EXP_W'((1 << EXP_W) - 2), {MAN_W{1'b1}}};
      return {2'b10, r};
    end
    if (e <= 0) return {2'b01, {W{1'b0}}};
    r = {sgn, EXP_W'(e), MAN_W'(q)};
    return {2'b00, r};
  endfunction

  function automatic logic [W-1:0] rand_op();
    int r;
    logic [EXP_W-1:0] e;
    r = int'($urandom_range(0, 7));
    if (r == 0)      e = '0;
    else if (r == 1) e = EXP_W'($urandom_range(1, 20));
    else if (r == 2) e = EXP_W'($urandom_range(235, 255));
    else             e = EXP_W'($urandom_range(60, 195));
    return {1'($urandom_range(0, 1)), e, MAN_W'($urandom)};
  endfunction

  // Entered just after a rising edge; samples outputs 1 time unit later, then waits one clock.
  task automatic drive_cycle(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic m, input logic ordy,
                             output logic fired, output logic [W+1:0] obs,
                             output logic acc, output logic rdy);
    in_valid = v; in_a = a; in_b = b; in_rnd_mode = m; out_ready = ordy;
    #1;
    rdy   = in_ready;
    acc   = v & in_ready;
    if (acc) expq.push_back(ref_mul(a, b, m));
    fired = out_valid & out_ready;
    obs   = {out_ovf, out_unf, out_result};
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_rnd_mode = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({out_valid, out_ovf, out_unf, out_result} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got valid=%b ovf=%b unf=%b res=%h want all zero", out_valid, out_ovf, out_unf, out_result);
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    logic [W-1:0] ta  [13] = '{19'h1FC00, 19'h5FE00, 19'h1FC01, 19'h1FC01, 19'h1FC03, 19'h3FBFF, 19'h00400,
                               19'h40000, 19'h1FDA8, 19'h1FDA8, 19'h00400, 19'h3FBFF, 19'h7FBFF};
    logic [W-1:0] tbv [13] = '{19'h20000, 19'h20000, 19'h1FE00, 19'h1FE00, 19'h1FE00, 19'h20000, 19'h1F800,
                               19'h5FE00, 19'h1FDA8, 19'h1FDA8, 19'h1FC00, 19'h1FC00, 19'h20000};
    logic         tm  [13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [W+1:0] te  [13] = '{21'h020000, 21'h060200, 21'h01FE02, 21'h01FE01, 21'h01FE04, 21'h13FBFF, 21'h080000,
                               21'h000000, 21'h020000, 21'h01FFFF, 21'h000400, 21'h03FBFF, 21'h17FBFF};
    logic fired, acc, rdy;
    logic [W+1:0] obs, ev;
    int lat;
    for (int i = 0; i < 13; i++) begin
      drive_cycle(1'b1, ta[i], tbv[i], tm[i], 1'b1, fired, obs, acc, rdy);
      lat = 0;
      for (int k = 1; k <= 6; k++) begin
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, fired, obs, acc, rdy);
        if (fired && lat == 0) begin
          lat = k;
          ev  = (expq.size() > 0) ? expq.pop_front() : '0;
          n_vec++;
          if (obs !== te[i]) begin
            n_err++;
            $display("FAIL directed[%0d] %h*%h m=%b: got {ovf,unf,res}=%h want %h", i, ta[i], tbv[i], tm[i], obs, te[i]);
          end
        end
      end
      n_vec++;
      if (lat !== 3) begin
        n_err++;
        $display("FAIL directed_latency[%0d]: got %0d want 3", i, lat);
      end
    end
    expq.delete();
  endtask

  task automatic test_random();
    logic fired, acc, rdy;
    logic [W+1:0] obs, ev;
    logic [W-1:0] a, b;
    for (int c = 0; c < 420; c++) begin
      a = rand_op();
      b = rand_op();
      drive_cycle(c < 400 && $urandom_range(0, 3) != 0, a, b, 1'($urandom_range(0, 1)),
                  c >= 400 || $urandom_range(0, 3) != 0, fired, obs, acc, rdy);
      if (fired) begin
        n_vec++;
        if (expq.size() == 0) begin
          n_err++;
          $display("FAIL random_spurious: got output %h want none", obs);
        end else begin
          ev = expq.pop_front();
          if (obs !== ev) begin
            n_err++;
            $display("FAIL random_result: got {ovf,unf,res}=%h want %h", obs, ev);
          end
        end
      end
    end
    n_vec++;
    if (expq.size() != 0) begin
      n_err++;
      $display("FAIL random_drain: got %0d results missing want 0", expq.size());
    end
    expq.delete();
  endtask

  task automatic test_back_to_back();
    logic fired, acc, rdy;
    logic [W+1:0] obs, ev, held;
    logic [W-1:0] pa [6], pb [6];
    int idx, nres;
    for (int i = 0; i < 6; i++) begin
      pa[i] = {1'($urandom_range(0, 1)), EXP_W'($urandom_range(100, 150)), MAN_W'($urandom)};
      pb[i] = {1'($urandom_range(0, 1)), EXP_W'($urandom_range(100, 150)), MAN_W'($urandom)};
    end
    idx = 0; nres = 0; held = '0;
    for (int c = 0; c < 40; c++) begin
      drive_cycle(idx < 6, (idx < 6) ? pa[idx] : '0, (idx < 6) ? pb[idx] : '0, 1'b0,
                  !(c >= 4 && c <= 7), fired, obs, acc, rdy);
      if (acc) idx++;
      if (c >= 4 && c <= 7) begin
        n_vec++;
        if (rdy !== 1'b0) begin
          n_err++;
          $display("FAIL stall_in_ready[c%0d]: got %b want 0", c, rdy);
        end
        if (c == 4) held = obs;
        else begin
          n_vec++;
          if (obs !== held || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL stall_hold[c%0d]: got %h valid=%b want %h valid=1", c, obs, out_valid, held);
          end
        end
      end
      if (fired) begin
        nres++;
        n_vec++;
        ev = (expq.size() > 0) ? expq.pop_front() : '1;
        if (obs !== ev) begin
          n_err++;
          $display("FAIL b2b_result[%0d]: got %h want %h", nres, obs, ev);
        end
      end
    end
    n_vec++;
    if (nres !== 6) begin
      n_err++;
      $display("FAIL b2b_count: got %0d results want 6", nres);
    end
    expq.delete();
  endtask

  task automatic test_bubbles();
    logic pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic ov [10];
    logic fired, acc, rdy;
    logic [W+1:0] obs, ev;
    for (int i = 0; i < 10; i++) begin
      drive_cycle((i < 5) ? pat[i] : 1'b0, rand_op(), rand_op(), 1'b0, 1'b1, fired, obs, acc, rdy);
      ov[i] = fired;
      if (fired) begin
        n_vec++;
        ev = (expq.size() > 0) ? expq.pop_front() : '1;
        if (obs !== ev) begin
          n_err++;
          $display("FAIL bubble_result[%0d]: got %h want %h", i, obs, ev);
        end
      end
    end
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (ov[i+3] !== pat[i]) begin
        n_err++;
        $display("FAIL bubble_pattern[%0d]: got out_valid=%b want %b", i, ov[i+3], pat[i]);
      end
    end
    expq.delete();
  endtask

  task automatic test_reset_midstream();
    logic fired, acc, rdy;
    logic [W+1:0] obs, ev;
    logic [W-1:0] a, b;
    int lat;
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, rand_op(), rand_op(), 1'b0, 1'b1, fired, obs, acc, rdy);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({out_valid, out_ovf, out_unf, out_result} !== '0) begin
      n_err++;
      $display("FAIL midreset_clear: got valid=%b ovf=%b unf=%b res=%h want all zero", out_valid, out_ovf, out_unf, out_result);
    end
    expq.delete();
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, fired, obs, acc, rdy);
      n_vec++;
      if (fired !== 1'b0) begin
        n_err++;
        $display("FAIL midreset_stale[%0d]: got out_valid=%b want 0", i, fired);
      end
    end
    a = {1'b0, 8'h80, MAN_W'($urandom)};
    b = {1'b1, 8'h7E, MAN_W'($urandom)};
    drive_cycle(1'b1, a, b, 1'b0, 1'b1, fired, obs, acc, rdy);
    lat = 0;
    for (int k = 1; k <= 6; k++) begin
      drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, fired, obs, acc, rdy);
      if (fired && lat == 0) begin
        lat = k;
        ev = (expq.size() > 0) ? expq.pop_front() : '1;
        n_vec++;
        if (obs !== ev) begin
          n_err++;
          $display("FAIL midreset_result: got %h want %h", obs, ev);
        end
      end
    end
    n_vec++;
    if (lat !== 3) begin
      n_err++;
      $display("FAIL midreset_latency: got %0d want 3", lat);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_bubbles();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
